uart_enigma_sequencer: RTL

// Sequences characters from the UART receiver through the Enigma cipher core and back to the UART transmitter.

---
 rtl/uart_enigma_sequencer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/uart_enigma_sequencer.sv
// Glue between uart_rx, the Enigma cipher core and uart_tx.
// Letters are queued as 0..25 indices, ciphered one at a time, sent as uppercase ASCII.
module uart_enigma_sequencer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int ENC_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [5:0] enc_in,
  output logic       enc_start,
  input  logic       enc_done,
  input  logic [5:0] enc_out,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic       fifo_full,
  output logic [7:0] drop_cnt,
  output logic       timeout_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(ENC_TIMEOUT + 1);

  localparam logic [AW:0]   DEPTH_P = (AW + 1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMO_MAX = TW'(ENC_TIMEOUT - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ISSUE    = 3'd1;
  localparam logic [2:0] WAIT_ENC = 3'd2;
  localparam logic [2:0] SEND     = 3'd3;
  localparam logic [2:0] WAIT_TX  = 3'd4;

  logic [2:0]    state;
  logic [5:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   wr_nxt;
  logic [AW:0]   rd_nxt;
  logic [TW-1:0] tmo_cnt;
  logic          is_upper;
  logic          is_lower;
  logic          do_wr;
  logic          do_pop;
  logic          fifo_empty;
  logic [5:0]    letter_idx;

  // Both cases share low five bits 0x01..0x1A for A..Z.
  always_comb begin
    is_upper   = (rx_data >= 8'h41) && (rx_data <= 8'h5A);
    is_lower   = (rx_data >= 8'h61) && (rx_data <= 8'h7A);
    letter_idx = {1'b0, rx_data[4:0] - 5'd1};
    do_wr      = rx_valid && (is_upper || is_lower) && !fifo_full;
    fifo_empty = (wr_ptr == rd_ptr);
    do_pop     = (state == IDLE) && !fifo_empty;
    wr_nxt     = wr_ptr + {{AW{1'b0}}, do_wr};
    rd_nxt     = rd_ptr + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr[AW-1:0]] <= letter_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_full <= 1'b0;
      drop_cnt  <= 8'd0;
    end else begin
      wr_ptr    <= wr_nxt;
      rd_ptr    <= rd_nxt;
      fifo_full <= ((wr_nxt - rd_nxt) == DEPTH_P);
      if (rx_valid && !do_wr && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      enc_in      <= 6'd0;
      enc_start   <= 1'b0;
      tx_data     <= 8'd0;
      tx_start    <= 1'b0;
      timeout_err <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      enc_start <= 1'b0;
      tx_start  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (do_pop) begin
            enc_in <= mem[rd_ptr[AW-1:0]];
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          enc_start <= 1'b1;
          tmo_cnt   <= '0;
          state     <= WAIT_ENC;
        end
        WAIT_ENC: begin
          if (enc_done) begin
            tx_data <= {2'b01, enc_out} + 8'd1;
            state   <= SEND;
          end else if (tmo_cnt == TMO_MAX) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        SEND: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            state    <= WAIT_TX;
          end
        end
        WAIT_TX: begin
          // The pulse cycle gives the transmitter time to raise busy.
          if (!tx_start && !tx_busy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
